// File: rtl/stat_poll_pkg.sv
// stat_poll_pkg -- shared types and default constants for the statistics poller.
//   state_t      : poller FSM state encoding (IDLE, REQ, WAIT, OUT)
//   DEF_A_WIDTH  : default flow-number width (2**DEF_A_WIDTH flows per sweep)
//   DEF_D_WIDTH  : default statistics word width
//   DEF_TIMEOUT  : default read-data wait limit in cycles (used only when
//                  STAT_POLL_TIMEOUT_EN is defined)
package stat_poll_pkg;

   localparam int DEF_A_WIDTH = 3;
   localparam int DEF_D_WIDTH = 32;
   localparam int DEF_TIMEOUT = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

endpackage

// File: rtl/stat_poll.sv
// stat_poll -- sweeps every flow of a statistics block, reads one word per
// flow and exports it to a downstream sink.
//
// Ports
//   clk_i, rst_n_i        clock (rising edge), asynchronous active-low reset
//   start_i               one-cycle pulse that begins a sweep (ignored while busy)
//   busy_o, done_o        sweep in progress / one-cycle sweep-complete pulse
//   rd_stb_o              one-cycle read strobe to the statistics block
//   rd_flow_num_o         flow being read; holds its value between strobes
//   rd_data_i             read data
//   rd_data_val_i         read data valid; only looked at while waiting for data
//   out_flow_num_o        flow number of the exported word
//   out_data_o            exported statistics word
//   out_err_o             exported word is a zero word substituted after a read timeout
//   out_val_o, out_rdy_i  export handshake
//   dbg_state             current FSM state, for observation only
//
// Export handshake: a word transfers on every cycle where out_val_o and
// out_rdy_i are both high. Once out_val_o rises it stays high, and
// out_flow_num_o / out_data_o / out_err_o stay constant, until that transfer.
//
// Build option STAT_POLL_TIMEOUT_EN: when defined, a wait for read data is
// abandoned after TIMEOUT cycles and a zero word with out_err_o=1 is exported
// instead. When undefined, the poller waits indefinitely and out_err_o is 0.
module stat_poll
   import stat_poll_pkg::*;
#(
   parameter int A_WIDTH = DEF_A_WIDTH,
   parameter int D_WIDTH = DEF_D_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               start_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               rd_stb_o,
   output logic [A_WIDTH-1:0] rd_flow_num_o,
   input  logic [D_WIDTH-1:0] rd_data_i,
   input  logic               rd_data_val_i,
   output logic [A_WIDTH-1:0] out_flow_num_o,
   output logic [D_WIDTH-1:0] out_data_o,
   output logic               out_err_o,
   output logic               out_val_o,
   input  logic               out_rdy_i,
   output state_t             dbg_state
);

   localparam logic [A_WIDTH-1:0] LAST_FLOW = '1;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("stat_poll: TIMEOUT must be at least 1");
   end

   state_t             state, state_nxt;
   logic [A_WIDTH-1:0] cnt, cnt_nxt;
   logic               done_nxt;
   logic               ld_data;
   logic               ld_tmo;
   logic               tmo_hit;

   // ---------------------------------------------------------------------
   // Optional read-data timeout
   // ---------------------------------------------------------------------
`ifdef STAT_POLL_TIMEOUT_EN
   localparam int            TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] tmo_cnt;
   logic          err_q;

   // Counts WAIT cycles; zero on the first WAIT cycle, so the hit fires on
   // the TIMEOUT-th cycle spent waiting.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tmo_cnt <= '0;
      end else if (state == ST_WAIT) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
         tmo_cnt <= '0;
      end
   end

   assign tmo_hit = (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         err_q <= 1'b0;
      end else if (ld_data) begin
         err_q <= 1'b0;
      end else if (ld_tmo) begin
         err_q <= 1'b1;
      end
   end

   assign out_err_o = err_q;
`else
   assign tmo_hit   = 1'b0;
   assign out_err_o = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         done_o <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         done_o <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      ld_data   = 1'b0;
      ld_tmo    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_i) begin
               cnt_nxt   = '0;
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (rd_data_val_i) begin
               ld_data   = 1'b1;
               state_nxt = ST_OUT;
            end else if (tmo_hit) begin
               ld_tmo    = 1'b1;
               state_nxt = ST_OUT;
            end
         end
         ST_OUT: begin
            if (out_rdy_i) begin
               // The last flow ends the sweep; the counter never wraps.
               if (cnt == LAST_FLOW) begin
                  done_nxt  = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  cnt_nxt   = cnt + 1'b1;
                  state_nxt = ST_REQ;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Export register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         out_data_o     <= '0;
         out_flow_num_o <= '0;
      end else if (ld_data) begin
         out_data_o     <= rd_data_i;
         out_flow_num_o <= cnt;
      end else if (ld_tmo) begin
         out_data_o     <= '0;
         out_flow_num_o <= cnt;
      end
   end

   // The flow counter only moves on a start or an export handshake, so it
   // already holds steady between strobes and can drive the read address.
   assign rd_flow_num_o = cnt;
   assign rd_stb_o      = (state == ST_REQ);
   assign out_val_o     = (state == ST_OUT);
   assign busy_o        = (state != ST_IDLE);
   assign dbg_state     = state;

endmodule

// File: tb/tb_stat_poll.sv
// tb_stat_poll -- self-checking bench for stat_poll.
// A responder plays the statistics block (per-flow data table and latency),
// a sink drives out_rdy_i, and a transaction-level model predicts, per sweep,
// the ordered list of exported words, busy/done behaviour and strobe order.
// Build option STAT_POLL_TIMEOUT_EN additionally exercises the timeout path.
module tb_stat_poll;
   import stat_poll_pkg::*;

   localparam int A  = 3;
   localparam int D  = 32;
   localparam int TO = 15;
   localparam int NF = 1 << A;
   localparam int EW = 1 + A + D;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n_i;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- DUT ----------------
   logic         start_i;
   logic         busy_o, done_o, rd_stb_o, out_err_o, out_val_o, out_rdy_i;
   logic [A-1:0] rd_flow_num_o, out_flow_num_o;
   logic [D-1:0] rd_data_i, out_data_o;
   logic         rd_data_val_i;
   state_t       dbg_state;

   stat_poll #(.A_WIDTH(A), .D_WIDTH(D), .TIMEOUT(TO)) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n_i),
      .start_i        (start_i),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .rd_stb_o       (rd_stb_o),
      .rd_flow_num_o  (rd_flow_num_o),
      .rd_data_i      (rd_data_i),
      .rd_data_val_i  (rd_data_val_i),
      .out_flow_num_o (out_flow_num_o),
      .out_data_o     (out_data_o),
      .out_err_o      (out_err_o),
      .out_val_o      (out_val_o),
      .out_rdy_i      (out_rdy_i),
      .dbg_state      (dbg_state)
   );

   // ---------------- shared configuration (written by main only) -------
   logic [D-1:0] mem [NF];
   int           delay [NF];
   bit           silent [NF];
   bit           rdy_always;
   int           stall_flow;
   int           spur_cnt;

   // ---------------- counters ----------------
   int vectors;
   int miscompares;

   function automatic logic [EW-1:0] pack(input logic err, input logic [A-1:0] f,
                                          input logic [D-1:0] d);
      return {err, f, d};
   endfunction

   // ---------------- responder (statistics block) ----------------
   initial begin : responder
      int f;
      int d;
      int spur_done;
      rd_data_val_i = 1'b0;
      rd_data_i     = '0;
      spur_done     = 0;
      forever begin
         @(negedge clk);
         if (spur_cnt != spur_done) begin
            spur_done = spur_cnt;
            @(posedge clk); #1;
            rd_data_val_i = 1'b1;
            rd_data_i     = $urandom;
            @(posedge clk); #1;
            rd_data_val_i = 1'b0;
         end else if (rst_n_i && rd_stb_o && !silent[rd_flow_num_o]) begin
            f = int'(rd_flow_num_o);
            d = delay[f];
            @(posedge clk);
            repeat (d) @(posedge clk);
            #1;
            rd_data_val_i = 1'b1;
            rd_data_i     = mem[f];
            @(posedge clk); #1;
            rd_data_val_i = 1'b0;
            rd_data_i     = $urandom;
         end
      end
   end

   // ---------------- sink (out_rdy_i) ----------------
   initial begin : sink
      int   stall_left;
      logic prev_val;
      out_rdy_i  = 1'b0;
      stall_left = 0;
      prev_val   = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (out_val_o && !prev_val && int'(out_flow_num_o) == stall_flow) stall_left = 5;
         prev_val = out_val_o;
         if (stall_left > 0) begin
            out_rdy_i  = 1'b0;
            stall_left = stall_left - 1;
         end else begin
            out_rdy_i = rdy_always ? 1'b1 : ($urandom_range(0, 2) != 0);
         end
      end
   end

   // ---------------- model + scoreboard + compare ----------------
   logic [EW-1:0] exp_q [$];
   bit            active;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors = vectors + 1;
      if (act !== exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   initial begin : compare
      bit            done_exp;
      int            nexp;
      bit            prev_hold;
      logic [EW-1:0] prev_word;
      logic [EW-1:0] word;
      int            val_run;
      int            busy_len;
      int            sweep_no;
      int            wd;
      int            cyc;
      int            strobe_cyc;
      bit            hs;
      logic [D-1:0]  cap [NF];
      logic [D-1:0]  first_exp [NF];
      first_exp = '{32'd0, 32'd100, 32'd200, 32'd300, 32'd400, 32'd500, 32'd600, 32'd700};
      active = 0; done_exp = 0; nexp = 0; prev_hold = 0; prev_word = '0;
      val_run = 0; busy_len = 0; sweep_no = 0; wd = 0; cyc = 0; strobe_cyc = 0;
      forever begin
         @(negedge clk);
         cyc  = cyc + 1;
         word = pack(out_err_o, out_flow_num_o, out_data_o);
         if (!rst_n_i) begin
            chk("reset_outputs", 64'({busy_o, done_o, rd_stb_o, out_val_o, out_err_o,
                                     rd_flow_num_o, out_flow_num_o, out_data_o}), 64'd0);
            exp_q.delete();
            active = 0; done_exp = 0; prev_hold = 0; val_run = 0; wd = 0;
         end else begin
            chk("busy", 64'(busy_o), 64'(active));
            chk("done", 64'(done_o), 64'(done_exp));
            if (rd_stb_o) begin
               chk("strobe_flow", 64'(rd_flow_num_o), 64'(nexp));
               strobe_cyc = cyc;
            end
            if (out_val_o) begin
               chk("export_in_sweep", 64'(active), 64'd1);
               chk("rd_flow_hold", 64'(rd_flow_num_o), 64'(out_flow_num_o));
            end
            if (prev_hold) chk("export_hold", 64'({out_val_o, word}), 64'({1'b1, prev_word}));
            val_run = out_val_o ? val_run + 1 : 0;
`ifdef STAT_POLL_TIMEOUT_EN
            if (out_val_o && out_err_o && val_run == 1)
               chk("timeout_latency", 64'(cyc - strobe_cyc), 64'd16);
`endif
            if (active) busy_len = busy_len + 1;
            hs = out_val_o && out_rdy_i;
            if (hs) begin
               if (exp_q.size() == 0) chk("export_unexpected", 64'(word), 64'h0);
               else chk("export", 64'(word), 64'(exp_q.pop_front()));
               if (sweep_no == 0) cap[out_flow_num_o] = out_data_o;
               if (stall_flow == 2 && out_flow_num_o == 3'd2) begin
                  chk("stall_len", 64'(val_run), 64'd6);
                  chk("stall_data", 64'(out_data_o), 64'd200);
               end
            end
            prev_hold = out_val_o && !out_rdy_i;
            prev_word = word;
            // advance the model to the next cycle
            done_exp = 0;
            if (active && hs) begin
               nexp = nexp + 1;
               if (nexp == NF) begin
                  active   = 0;
                  done_exp = 1;
                  chk("sweep_leftover", 64'(exp_q.size()), 64'd0);
                  if (sweep_no == 0) begin
                     for (int i = 0; i < NF; i++) chk("first_sweep_data", 64'(cap[i]), 64'(first_exp[i]));
                     chk("first_sweep_cycles", 64'(busy_len), 64'd24);
                  end
                  sweep_no = sweep_no + 1;
               end
            end else if (!active && start_i) begin
               active   = 1;
               nexp     = 0;
               busy_len = 0;
               exp_q.delete();
               for (int i = 0; i < NF; i++) begin
`ifdef STAT_POLL_TIMEOUT_EN
                  if (silent[i]) exp_q.push_back(pack(1'b1, A'(i), '0));
                  else exp_q.push_back(pack(1'b0, A'(i), mem[i]));
`else
                  exp_q.push_back(pack(1'b0, A'(i), mem[i]));
`endif
               end
            end
            wd = active ? wd + 1 : 0;
            if (wd > 3000) begin
               chk("sweep_watchdog", 64'(wd), 64'd3000);
               active = 0;
               wd     = 0;
               exp_q.delete();
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_start();
      @(posedge clk); #1;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_idle();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4000; i++) begin
         if (!busy_o && !active) break;
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_strobe(input int f);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (rd_stb_o && int'(rd_flow_num_o) == f) break;
      end
   endtask

   task automatic set_directed();
      for (int i = 0; i < NF; i++) begin
         mem[i]    = D'(i * 100);
         delay[i]  = 0;
         silent[i] = 1'b0;
      end
      rdy_always = 1'b1;
   endtask

   task automatic set_random();
      for (int i = 0; i < NF; i++) begin
         mem[i]    = $urandom;
         delay[i]  = $urandom_range(0, 3);
         silent[i] = 1'b0;
      end
      rdy_always = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      vectors     = 0;
      miscompares = 0;
      rst_n_i     = 1'b0;
      start_i     = 1'b0;
      stall_flow  = -1;
      spur_cnt    = 0;
      set_directed();
      repeat (3) @(posedge clk);
      #1 rst_n_i = 1'b1;

      // directed sweep: data = flow*100, zero latency, sink always ready
      pulse_start();
      wait_idle();

      // sink stalls for 5 cycles on flow 2
      stall_flow = 2;
      pulse_start();
      wait_idle();
      stall_flow = -1;

      // start pulsed again mid-sweep is ignored
      set_random();
      pulse_start();
      wait_strobe(4);
      pulse_start();
      wait_idle();

      // random sweeps
      for (int s = 0; s < 5; s++) begin
         set_random();
         pulse_start();
         wait_idle();
      end

`ifdef STAT_POLL_TIMEOUT_EN
      // responder never answers flow 3
      set_random();
      silent[3] = 1'b1;
      pulse_start();
      wait_idle();
      silent[3] = 1'b0;
`endif

      // spurious read-data valid while idle
      spur_cnt = spur_cnt + 1;
      repeat (6) @(posedge clk);

      // reset during WAIT of flow 5; the late data arrives after release
      set_directed();
      delay[5] = 6;
      pulse_start();
      wait_strobe(5);
      @(posedge clk); #3;
      rst_n_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n_i = 1'b1;
      repeat (12) @(posedge clk);

      // recovery sweep after the abandoned one
      set_random();
      pulse_start();
      wait_idle();

      repeat (2) @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
